// File: rtl/scaler_frame_tx_pkg.sv
// Shared constants, state encoding and payload types for the scaler frame transmitter.
package scaler_frame_tx_pkg;

  localparam int unsigned NCH       = 8;
  localparam int unsigned CW        = 24;
  localparam int unsigned BUSW      = NCH * CW;
  localparam int unsigned BPB       = CW / 8;
  localparam int unsigned FRAME_LEN = 4 + NCH * BPB;
  localparam int unsigned NDAT      = FRAME_LEN - 4;
  localparam int unsigned IDXW      = 5;

  localparam logic [7:0] HDR = 8'hA5;

  localparam int unsigned FLG_TS     = 0;
  localparam int unsigned FLG_SHADOW = 1;
  localparam int unsigned FLG_MISSED = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_FLG,
    S_DAT,
    S_CSM
  } state_t;

  typedef struct packed {
    logic            ts_ok;
    logic [BUSW-1:0] bus;
  } snap_t;

  // Data byte idx of a snapshot: band-major, MSB byte first within each band.
  function automatic logic [7:0] band_byte(input logic [BUSW-1:0] bus,
                                           input logic [IDXW-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < NCH; k++) begin
      for (int j = 0; j < BPB; j++) begin
        if (idx == IDXW'(k * BPB + j)) b = bus[k*CW + CW - 8 - 8*j +: 8];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/scaler_frame_tx_frame_snapshot_buf.sv
// Active/shadow snapshot registers with load, promote and drop handling plus drop counter.
module frame_snapshot_buf
  import scaler_frame_tx_pkg::*;
(
  input  logic            clk_r2,
  input  logic            reset,
  input  logic            snap,
  input  logic            idle,
  input  logic            csm_acc,
  input  logic            flg_acc,
  input  logic            time_stamp_ok,
  input  logic [BUSW-1:0] scaler_bus,
  output snap_t           active,
  output logic            shadow_full,
  output logic [7:0]      drop_cnt,
  output logic            shadow_full_nxt_c,
  output logic            missed_nxt_c
);

  snap_t      sample;
  snap_t      shadow;
  snap_t      active_nxt;
  snap_t      shadow_nxt;
  logic       missed;
  logic       drop;
  logic [7:0] drop_cnt_nxt;

  assign sample = {time_stamp_ok, scaler_bus};

  // Promotion at end of frame takes priority; a new sample then refills the shadow.
  always_comb begin
    active_nxt        = active;
    shadow_nxt        = shadow;
    shadow_full_nxt_c = shadow_full;
    drop              = 1'b0;
    if (idle) begin
      if (snap) active_nxt = sample;
    end else if (csm_acc) begin
      if (shadow_full) begin
        active_nxt = shadow;
        if (snap) shadow_nxt = sample;
        else      shadow_full_nxt_c = 1'b0;
      end else if (snap) begin
        active_nxt = sample;
      end
    end else if (snap) begin
      if (!shadow_full) begin
        shadow_nxt        = sample;
        shadow_full_nxt_c = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    missed_nxt_c = drop ? 1'b1 : (flg_acc ? 1'b0 : missed);
    drop_cnt_nxt = (drop && (drop_cnt != 8'hFF)) ? drop_cnt + 8'd1 : drop_cnt;
  end

  always_ff @(posedge clk_r2 or posedge reset) begin
    if (reset) begin
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      missed      <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      active      <= active_nxt;
      shadow      <= shadow_nxt;
      shadow_full <= shadow_full_nxt_c;
      missed      <= missed_nxt_c;
      drop_cnt    <= drop_cnt_nxt;
    end
  end

endmodule

// File: rtl/scaler_frame_tx.sv
// Serialises scaler snapshots into 28-byte checksummed frames over a valid/ready byte link.
module scaler_frame_tx
  import scaler_frame_tx_pkg::*;
(
  input  logic            clk_r2,
  input  logic            reset,
  input  logic            tick,
  input  logic            time_stamp_ok,
  input  logic [BUSW-1:0] scaler_bus,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [7:0]      drop_cnt
);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_nxt;
  logic            tick_d;
  logic [7:0]      seq;
  logic [7:0]      csum;
  logic [7:0]      byte_nxt;
  logic [7:0]      flags;
  logic            snap;
  logic            acc;
  snap_t           active;
  logic            shadow_full;
  logic            shadow_full_nxt_c;
  logic            missed_nxt_c;

  assign snap = tick & ~tick_d;
  assign acc  = out_valid & out_ready;

  frame_snapshot_buf u_buf (
    .clk_r2            (clk_r2),
    .reset             (reset),
    .snap              (snap),
    .idle              (state == S_IDLE),
    .csm_acc           (acc && (state == S_CSM)),
    .flg_acc           (acc && (state == S_FLG)),
    .time_stamp_ok     (time_stamp_ok),
    .scaler_bus        (scaler_bus),
    .active            (active),
    .shadow_full       (shadow_full),
    .drop_cnt          (drop_cnt),
    .shadow_full_nxt_c (shadow_full_nxt_c),
    .missed_nxt_c      (missed_nxt_c)
  );

  always_ff @(posedge clk_r2 or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: if (snap) state_nxt = S_HDR;
      S_HDR:  if (acc) state_nxt = S_SEQ;
      S_SEQ:  if (acc) state_nxt = S_FLG;
      S_FLG: begin
        if (acc) begin
          state_nxt = S_DAT;
          idx_nxt   = '0;
        end
      end
      S_DAT: begin
        if (acc) begin
          if (idx == IDXW'(NDAT - 1)) state_nxt = S_CSM;
          else                        idx_nxt   = idx + IDXW'(1);
        end
      end
      S_CSM:  if (acc) state_nxt = (shadow_full || snap) ? S_HDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte to present next cycle; flags reflect buffer state as of presentation.
  always_comb begin
    flags             = '0;
    flags[FLG_TS]     = active.ts_ok;
    flags[FLG_SHADOW] = shadow_full_nxt_c;
    flags[FLG_MISSED] = missed_nxt_c;
    case (state_nxt)
      S_HDR:   byte_nxt = HDR;
      S_SEQ:   byte_nxt = seq;
      S_FLG:   byte_nxt = flags;
      S_DAT:   byte_nxt = band_byte(active.bus, idx_nxt);
      S_CSM:   byte_nxt = csum ^ out_data;
      default: byte_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_r2 or posedge reset) begin
    if (reset) begin
      tick_d    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      seq       <= '0;
      csum      <= '0;
    end else begin
      tick_d    <= tick;
      out_valid <= (state_nxt != S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      if (!(out_valid && !out_ready)) out_data <= byte_nxt;
      if (acc) begin
        if (state == S_CSM) begin
          csum <= '0;
          seq  <= seq + 8'd1;
        end else begin
          csum <= csum ^ out_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_scaler_frame_tx.sv
// Randomised bench for scaler_frame_tx against a byte-position frame model.
module tb_scaler_frame_tx;

  logic         clk_r2 = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0;
  logic         time_stamp_ok = 1'b0;
  logic         out_ready = 1'b0;
  logic [191:0] scaler_bus = '0;
  logic [7:0]   out_data;
  logic [7:0]   drop_cnt;
  logic         out_valid;
  logic         busy;

  always #5 clk_r2 = ~clk_r2;

  scaler_frame_tx dut (
    .clk_r2        (clk_r2),
    .reset         (reset),
    .tick          (tick),
    .time_stamp_ok (time_stamp_ok),
    .scaler_bus    (scaler_bus),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame in flight, byte position, active/shadow captures.
  bit           m_in, m_sh_v, m_missed, m_cur_ts, m_sh_ts, m_tick_d;
  int           m_pos, m_drop;
  logic [191:0] m_cur, m_sh;
  logic [7:0]   m_seq, m_flag;
  logic [7:0]   obs_seq[$];
  logic [7:0]   obs_flag[$];

  task automatic model_reset();
    m_in = 0; m_sh_v = 0; m_missed = 0; m_tick_d = 0;
    m_pos = 0; m_drop = 0; m_seq = '0; m_flag = '0;
  endtask

  function automatic logic [7:0] base_byte(input int p);
    int d;
    if (p == 0) return 8'hA5;
    if (p == 1) return m_seq;
    if (p == 2) return m_flag;
    d = p - 3;
    return m_cur[(d / 3) * 24 + 16 - 8 * (d % 3) +: 8];
  endfunction

  function automatic logic [7:0] frame_byte(input int p);
    logic [7:0] x;
    if (p < 27) return base_byte(p);
    x = '0;
    for (int q = 0; q < 27; q++) x ^= base_byte(q);
    return x;
  endfunction

  task automatic model_update();
    bit snap, acc, drop;
    int old_pos;
    snap = tick && !m_tick_d;
    acc  = m_in && out_ready;
    drop = 0;
    old_pos = m_pos;
    if (acc && m_pos == 1) obs_seq.push_back(out_data);
    if (acc && m_pos == 2) obs_flag.push_back(out_data);
    if (!m_in) begin
      if (snap) begin
        m_cur = scaler_bus; m_cur_ts = time_stamp_ok; m_in = 1; m_pos = 0;
      end
    end else if (acc && m_pos == 27) begin
      m_seq++;
      m_pos = 0;
      if (m_sh_v) begin
        m_cur = m_sh; m_cur_ts = m_sh_ts;
        if (snap) begin m_sh = scaler_bus; m_sh_ts = time_stamp_ok; end
        else m_sh_v = 0;
      end else if (snap) begin
        m_cur = scaler_bus; m_cur_ts = time_stamp_ok;
      end else begin
        m_in = 0;
      end
    end else begin
      if (acc) m_pos++;
      if (snap) begin
        if (!m_sh_v) begin
          m_sh = scaler_bus; m_sh_ts = time_stamp_ok; m_sh_v = 1;
        end else begin
          drop = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (acc && old_pos == 2) m_missed = 0;
    if (drop) m_missed = 1;
    if (acc && old_pos == 1) m_flag = {5'b0, m_missed, m_sh_v, m_cur_ts};
    m_tick_d = tick;
  endtask

  // One clock: check outputs on the falling edge, advance model, return just after rising edge.
  task automatic step();
    @(negedge clk_r2);
    if (reset) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      model_reset();
    end else begin
      check("valid", 32'(out_valid), 32'(m_in));
      check("busy", 32'(busy), 32'(m_in));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (m_in) check($sformatf("byte%0d", m_pos), 32'(out_data), 32'(frame_byte(m_pos)));
      model_update();
    end
    @(posedge clk_r2);
    #1;
  endtask

  function automatic logic [191:0] rand_bus();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step_r();
    scaler_bus = rand_bus();
    step();
  endtask

  task automatic run_idle(input int lim);
    for (int i = 0; i < lim && m_in; i++) step();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    step(); step();
    reset = 1'b0;
    step();

    // Single frame with ramp pattern.
    time_stamp_ok = 1'b1;
    for (int k = 0; k < 8; k++) scaler_bus[k*24 +: 24] = 24'(24'h010203 * (k + 1));
    obs_seq.delete(); obs_flag.delete();
    out_ready = 1'b1;
    tick = 1'b1; step(); tick = 1'b0;
    run_idle(60);
    check("s1_frames", 32'(obs_seq.size()), 32'd1);
    check("s1_seq", 32'(obs_seq[0]), 32'd0);
    check("s1_flags", 32'(obs_flag[0]), 32'h01);

    // Same frame under random backpressure.
    obs_seq.delete(); obs_flag.delete();
    tick = 1'b1; out_ready = 1'($urandom_range(0, 1)); step(); tick = 1'b0;
    for (int i = 0; i < 200 && m_in; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    run_idle(60);
    check("s2_frames", 32'(obs_seq.size()), 32'd1);
    check("s2_seq", 32'(obs_seq[0]), 32'd1);

    // Shadow fills while stalled at HDR, third tick drops.
    obs_seq.delete(); obs_flag.delete();
    out_ready = 1'b0;
    tick = 1'b1; step_r(); tick = 1'b0;
    for (int i = 0; i < 4; i++) step_r();
    tick = 1'b1; step_r(); tick = 1'b0;
    step_r();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && m_pos < 10; i++) step_r();
    tick = 1'b1; step_r(); tick = 1'b0;
    run_idle(100);
    check("s3_drop", 32'(drop_cnt), 32'd1);
    check("s3_frames", 32'(obs_seq.size()), 32'd2);
    check("s3_seq0", 32'(obs_seq[0]), 32'd2);
    check("s3_seq1", 32'(obs_seq[1]), 32'd3);
    check("s3_flags0", 32'(obs_flag[0]), 32'h03);
    check("s3_flags1", 32'(obs_flag[1]), 32'h05);

    // Tick edge coincident with CSM acceptance while shadow is full.
    obs_seq.delete(); obs_flag.delete();
    tick = 1'b1; step_r(); tick = 1'b0;
    for (int i = 0; i < 3; i++) step_r();
    tick = 1'b1; step_r(); tick = 1'b0;
    for (int i = 0; i < 80 && !(m_in && m_pos == 27); i++) step_r();
    tick = 1'b1; step_r(); tick = 1'b0;
    run_idle(150);
    check("s4_frames", 32'(obs_seq.size()), 32'd3);
    check("s4_seq0", 32'(obs_seq[0]), 32'd4);
    check("s4_seq1", 32'(obs_seq[1]), 32'd5);
    check("s4_seq2", 32'(obs_seq[2]), 32'd6);
    check("s4_drop", 32'(drop_cnt), 32'd1);

    // Random ticks, backpressure, timestamp status and data.
    for (int i = 0; i < 600; i++) begin
      tick          = ($urandom_range(0, 11) == 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      time_stamp_ok = 1'($urandom_range(0, 1));
      step_r();
    end
    tick = 1'b0; out_ready = 1'b1;
    run_idle(200);

    // Held tick gives one snapshot; forced drops saturate the counter.
    obs_seq.delete(); obs_flag.delete();
    tick = 1'b1;
    for (int i = 0; i < 100; i++) step_r();
    tick = 1'b0;
    run_idle(60);
    check("s5_one_frame", 32'(obs_seq.size()), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 302; i++) begin
      tick = 1'b1; step_r();
      tick = 1'b0; step_r();
    end
    check("s5_drop_sat", 32'(drop_cnt), 32'hFF);
    out_ready = 1'b1;
    run_idle(200);

    // Reset in the middle of data byte 10.
    obs_seq.delete(); obs_flag.delete();
    tick = 1'b1; step_r(); tick = 1'b0;
    for (int i = 0; i < 40 && m_pos != 13; i++) step_r();
    reset = 1'b1;
    #1;
    check("s6_async_valid", 32'(out_valid), 32'd0);
    check("s6_async_busy", 32'(busy), 32'd0);
    step(); step();
    reset = 1'b0;
    step();
    obs_seq.delete(); obs_flag.delete();
    tick = 1'b1; step_r(); tick = 1'b0;
    run_idle(60);
    check("s6_frames", 32'(obs_seq.size()), 32'd1);
    check("s6_seq", 32'(obs_seq[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
